lisa_imem_prefetch: RTL and testbench

- Parametrised successor instruction memory for the LISA core. Adds a registered prefetch byte buffer in front of the byte array.
- Presents a FETCH_BYTES window with a valid-byte count and its PC. The core consumes 1..FETCH_BYTES bytes per instruction, so variable-length decode never waits on array reads.
- Supports branch redirect and a testbench loader; a loader write flushes the buffer so fetched bytes stay coherent with memory.

---
 rtl/lisa_imem_pkg.sv | 19 +
 rtl/lisa_fetch_buf.sv | 79 +++++++
 rtl/lisa_imem_prefetch.sv | 161 ++++++++++++++++
 tb/tb_lisa_imem_prefetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lisa_imem_pkg.sv
// Shared constants and helpers for the LISA prefetching instruction memory.
package lisa_imem_pkg;

  localparam int unsigned MemBytesDef   = 512;
  localparam int unsigned FetchBytesDef = 16;
  localparam int unsigned BufBytesDef   = 32;
  localparam int unsigned ReadBytesDef  = 4;

  localparam int unsigned PC_W = 16;

  // Value delivered for any byte fetched from beyond the array.
  localparam logic [7:0] FillByte = 8'h00;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lisa_fetch_buf.sv
// Circular byte buffer: fixed-width push at tail, variable-length pop at head,
// and a combinational window of up to FETCH_BYTES bytes from the head.
module lisa_fetch_buf
  import lisa_imem_pkg::*;
#(
  parameter int unsigned BUF_BYTES   = BufBytesDef,
  parameter int unsigned FETCH_BYTES = FetchBytesDef,
  parameter int unsigned READ_BYTES  = ReadBytesDef,
  localparam int unsigned CW = cnt_width(FETCH_BYTES),
  localparam int unsigned BW = cnt_width(BUF_BYTES),
  localparam int unsigned PW = $clog2(BUF_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [READ_BYTES*8-1:0]  push_data,
  input  logic                     pop,
  input  logic [CW-1:0]            pop_len,
  output logic [BW-1:0]            count,
  output logic [FETCH_BYTES*8-1:0] window,
  output logic [CW-1:0]            window_bytes
);

  logic [7:0]    buf_q [BUF_BYTES];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [BW-1:0] count_q, count_d;

  // Pointer and occupancy next-state; flush empties the buffer outright.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(READ_BYTES);
      if (pop)  head_d = head_q + PW'(pop_len);
      count_d = count_q + (push ? BW'(READ_BYTES) : BW'(0)) - (pop ? BW'(pop_len) : BW'(0));
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Byte storage; contents beyond count are never exposed so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      for (int j = 0; j < int'(READ_BYTES); j++) begin
        buf_q[tail_q + PW'(j)] <= push_data[8*j +: 8];
      end
    end
  end

  // Head window with invalid lanes forced to zero.
  always_comb begin
    window       = '0;
    window_bytes = (count_q > BW'(FETCH_BYTES)) ? CW'(FETCH_BYTES) : CW'(count_q);
    for (int i = 0; i < int'(FETCH_BYTES); i++) begin
      if (i < int'(window_bytes)) window[8*i +: 8] = buf_q[head_q + PW'(i)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lisa_imem_prefetch.sv
// LISA instruction memory with a registered prefetch buffer in front of the byte array.
// Optional macro LISA_IMEM_FAULT_EN enables the sticky fetch_fault flag for
// refills that touch addresses beyond the array.
module lisa_imem_prefetch
  import lisa_imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = MemBytesDef,
  parameter int unsigned FETCH_BYTES = FetchBytesDef,
  parameter int unsigned BUF_BYTES   = BufBytesDef,
  parameter int unsigned READ_BYTES  = ReadBytesDef,
  localparam int unsigned CW = cnt_width(FETCH_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_we,
  input  logic [15:0]              load_addr,
  input  logic [7:0]               load_data,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_addr,
  input  logic                     consume_valid,
  input  logic [CW-1:0]            consume_len,
  output logic [FETCH_BYTES*8-1:0] fetch_window,
  output logic [CW-1:0]            window_bytes,
  output logic [15:0]              window_pc,
  output logic                     consume_err,
  output logic                     fetch_fault
);

  localparam int unsigned  AW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned  BW     = cnt_width(BUF_BYTES);
  localparam logic [PC_W:0] MemLim = (PC_W + 1)'(MEM_BYTES);

  // Array starts zeroed at time zero; rst deliberately leaves it alone.
  logic [7:0] mem_q [MEM_BYTES] = '{default: FillByte};

  logic [PC_W-1:0]          window_pc_q, window_pc_d;
  logic [PC_W-1:0]          fill_pc_q, fill_pc_d;
  logic                     err_q, err_d;
  logic [PC_W-1:0]          rd_addr [READ_BYTES];
  logic [READ_BYTES*8-1:0]  rd_data;
  logic                     buf_flush, buf_push, buf_pop;
  logic [BW-1:0]            buf_count;
  logic                     has_space;
`ifdef LISA_IMEM_FAULT_EN
  logic                     rd_oob;
  logic                     fault_q, fault_d;
`endif

  // Loader write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (load_we && ({1'b0, load_addr} < MemLim)) mem_q[load_addr[AW-1:0]] <= load_data;
  end

  // Refill read of READ_BYTES consecutive bytes from fill_pc, zero beyond the array.
  always_comb begin
    rd_addr = '{default: '0};
    rd_data = '0;
`ifdef LISA_IMEM_FAULT_EN
    rd_oob  = 1'b0;
`endif
    for (int j = 0; j < int'(READ_BYTES); j++) begin
      rd_addr[j] = fill_pc_q + PC_W'(j);
      if ({1'b0, rd_addr[j]} < MemLim) begin
        rd_data[8*j +: 8] = mem_q[rd_addr[j][AW-1:0]];
      end else begin
        rd_data[8*j +: 8] = FillByte;
`ifdef LISA_IMEM_FAULT_EN
        rd_oob = 1'b1;
`endif
      end
    end
  end

  // Free-space test uses the pre-consume count.
  assign has_space = buf_count <= BW'(BUF_BYTES - READ_BYTES);

  // Priority: redirect > loader flush > consume/refill.
  always_comb begin
    buf_flush   = 1'b0;
    buf_push    = 1'b0;
    buf_pop     = 1'b0;
    window_pc_d = window_pc_q;
    fill_pc_d   = fill_pc_q;
    err_d       = err_q;
`ifdef LISA_IMEM_FAULT_EN
    fault_d     = fault_q;
`endif
    if (redirect_valid) begin
      buf_flush   = 1'b1;
      window_pc_d = redirect_addr;
      fill_pc_d   = redirect_addr;
`ifdef LISA_IMEM_FAULT_EN
      fault_d     = 1'b0;
`endif
    end else if (load_we) begin
      buf_flush = 1'b1;
      fill_pc_d = window_pc_q;
    end else begin
      if (consume_valid) begin
        if (consume_len <= window_bytes) begin
          buf_pop     = 1'b1;
          window_pc_d = window_pc_q + PC_W'(consume_len);
        end else begin
          err_d = 1'b1;
        end
      end
      if (has_space) begin
        buf_push  = 1'b1;
        fill_pc_d = fill_pc_q + PC_W'(READ_BYTES);
`ifdef LISA_IMEM_FAULT_EN
        if (rd_oob) fault_d = 1'b1;
`endif
      end
    end
  end

  // PC and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_pc_q <= '0;
      fill_pc_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      window_pc_q <= window_pc_d;
      fill_pc_q   <= fill_pc_d;
      err_q       <= err_d;
    end
  end

`ifdef LISA_IMEM_FAULT_EN
  // Sticky out-of-range refill flag.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  lisa_fetch_buf #(
    .BUF_BYTES  (BUF_BYTES),
    .FETCH_BYTES(FETCH_BYTES),
    .READ_BYTES (READ_BYTES)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (buf_flush),
    .push        (buf_push),
    .push_data   (rd_data),
    .pop         (buf_pop),
    .pop_len     (consume_len),
    .count       (buf_count),
    .window      (fetch_window),
    .window_bytes(window_bytes)
  );

  assign window_pc   = window_pc_q;
  assign consume_err = err_q;

endmodule

// File: tb/tb_lisa_imem_prefetch.sv
// Scoreboard bench for lisa_imem_prefetch: stimulus queues expected state,
// a negedge monitor pops and compares.
module tb_lisa_imem_prefetch;

  localparam int MemBytes   = 512;
  localparam int FetchBytes = 16;
  localparam int CW         = $clog2(FetchBytes + 1);
`ifdef LISA_IMEM_FAULT_EN
  localparam logic FaultExp = 1'b1;
`else
  localparam logic FaultExp = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] pc;
    int          nb;
    logic [127:0] win;
    logic        err;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              load_we;
  logic [15:0]       load_addr;
  logic [7:0]        load_data;
  logic              redirect_valid;
  logic [15:0]       redirect_addr;
  logic              consume_valid;
  logic [CW-1:0]     consume_len;
  logic [127:0]      fetch_window;
  logic [CW-1:0]     window_bytes;
  logic [15:0]       window_pc;
  logic              consume_err;
  logic              fetch_fault;

  lisa_imem_prefetch dut (
    .clk           (clk),
    .rst           (rst),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .consume_valid (consume_valid),
    .consume_len   (consume_len),
    .fetch_window  (fetch_window),
    .window_bytes  (window_bytes),
    .window_pc     (window_pc),
    .consume_err   (consume_err),
    .fetch_fault   (fetch_fault)
  );

  logic [7:0] model_mem [MemBytes];
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [127:0] exp_win(input logic [15:0] pc, input int n);
    logic [127:0] w;
    logic [15:0]  a;
    w = '0;
    for (int i = 0; i < n; i++) begin
      a = pc + 16'(i);
      if (int'(a) < MemBytes) w[8*i +: 8] = model_mem[a[8:0]];
    end
    return w;
  endfunction

  task automatic expect_state(input string name, input logic [15:0] pc, input int nb,
                              input logic err, input logic fault);
    exp_t e;
    e.name  = name;
    e.pc    = pc;
    e.nb    = nb;
    e.win   = exp_win(pc, nb);
    e.err   = err;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "window_pc", 128'(window_pc), 128'(e.pc));
      chk(e.name, "window_bytes", 128'(window_bytes), 128'(e.nb));
      chk(e.name, "fetch_window", fetch_window, e.win);
      chk(e.name, "consume_err", 128'(consume_err), 128'(e.err));
      chk(e.name, "fetch_fault", 128'(fetch_fault), 128'(e.fault));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] addr, input logic [7:0] data);
    load_we   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick(1);
    load_we = 1'b0;
    if (int'(addr) < MemBytes) model_mem[addr[8:0]] = data;
  endtask

  task automatic consume(input int len);
    consume_valid = 1'b1;
    consume_len   = CW'(len);
    tick(1);
    consume_valid = 1'b0;
    consume_len   = '0;
  endtask

  task automatic redirect(input logic [15:0] addr);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < MemBytes; i++) model_mem[i] = 8'h00;
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    redirect_valid = 1'b0; redirect_addr = '0; consume_valid = 1'b0; consume_len = '0;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) load(16'(i), 8'(i));
    load(16'd510, 8'h5A);
    load(16'd511, 8'h5B);

    rst = 1'b1; tick(1); rst = 1'b0;
    expect_state("reset", 16'h0000, 0, 1'b0, 1'b0);
    tick(4);
    expect_state("fill", 16'h0000, 16, 1'b0, 1'b0);

    consume(3);
    expect_state("cons3", 16'h0003, 16, 1'b0, 1'b0);
    consume(5);
    expect_state("cons5", 16'h0008, 16, 1'b0, 1'b0);

    // Redirect wins over a same-edge consume.
    consume_valid = 1'b1; consume_len = CW'(4);
    redirect(16'h0100);
    consume_valid = 1'b0; consume_len = '0;
    expect_state("redir", 16'h0100, 0, 1'b0, 1'b0);
    tick(1);
    expect_state("redir_first", 16'h0100, 4, 1'b0, 1'b0);

    consume(6);
    expect_state("err_ignored", 16'h0100, 8, 1'b1, 1'b0);
    tick(3);
    expect_state("err_sticky", 16'h0100, 16, 1'b1, 1'b0);

    redirect(16'd510);
    expect_state("redir510", 16'd510, 0, 1'b1, 1'b0);
    tick(1);
    expect_state("oob_first", 16'd510, 4, 1'b1, FaultExp);
    tick(3);
    expect_state("oob_full", 16'd510, 16, 1'b1, FaultExp);
    redirect(16'h0000);
    expect_state("fault_clear", 16'h0000, 0, 1'b1, 1'b0);
    tick(1);
    expect_state("fault_stays0", 16'h0000, 4, 1'b1, 1'b0);

    rst = 1'b1; tick(1); rst = 1'b0;
    expect_state("rst2", 16'h0000, 0, 1'b0, 1'b0);
    tick(4);
    expect_state("full0", 16'h0000, 16, 1'b0, 1'b0);

    load(16'd2, 8'hAA);
    expect_state("load_flush", 16'h0000, 0, 1'b0, 1'b0);
    tick(1);
    expect_state("aa_first", 16'h0000, 4, 1'b0, 1'b0);
    tick(3);
    expect_state("aa_full", 16'h0000, 16, 1'b0, 1'b0);
    tick(4);

    // Buffer now full (32): consume exactly a whole window.
    consume(16);
    expect_state("cons16", 16'h0010, 16, 1'b0, 1'b0);
    consume(0);
    expect_state("cons0", 16'h0010, 16, 1'b0, 1'b0);

    // Out-of-range write still flushes and must not alias into the array.
    load(16'h0210, 8'h77);
    expect_state("oor_flush", 16'h0010, 0, 1'b0, 1'b0);
    tick(4);
    expect_state("oor_refill", 16'h0010, 16, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
